// File: rtl/vram_rd_sched.sv
// Shares the single VRAM read port between display scan-out (absolute priority)
// and a host burst reader that consumes idle cycles; flags host starvation.
module vram_rd_sched #(
  parameter int AW           = 14,
  parameter int DW           = 12,
  parameter int STARVE_LIMIT = 1023,
  parameter int SCW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_act,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          host_start,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_len,
  output logic          host_busy,
  output logic [DW-1:0] host_data,
  output logic          host_dvalid,
  output logic          host_done,
  output logic          host_starve,
  input  logic          starve_clr,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [SCW-1:0] LIMIT     = SCW'(STARVE_LIMIT);
  localparam logic [SCW-1:0] LIMIT_M1  = SCW'(STARVE_LIMIT - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [8:0]      rem_q, rem_d;
  logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
  logic            starve_q, starve_d;
  logic            disp_p1_q, disp_valid_q;
  logic            host_p1_q, host_dvalid_q, host_done_q, host_done_d;
  logic [DW-1:0]   disp_data_q, host_data_q;
  logic            host_issue;
  logic            starve_hit;

  // Host only gets the port when the display leaves it free.
  assign host_issue = (state_q == RUN) && !disp_act;
  assign addrb      = host_issue ? cur_addr_q : disp_addr;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    starve_cnt_d = starve_cnt_q;
    starve_hit   = 1'b0;
    host_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        starve_cnt_d = '0;
        if (host_start) begin
          cur_addr_d = host_addr;
          rem_d      = (host_len == 8'd0) ? 9'd256 : {1'b0, host_len};
          state_d    = RUN;
        end
      end
      RUN: begin
        if (host_issue) begin
          cur_addr_d   = cur_addr_q + 1'b1;
          rem_d        = rem_q - 9'd1;
          starve_cnt_d = '0;
          if (rem_q == 9'd1) state_d = DRAIN;
        end else if (starve_cnt_q != LIMIT) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
          starve_hit   = (starve_cnt_q == LIMIT_M1);
        end
      end
      DRAIN: begin
        // The only read still in flight here is the last one of the burst.
        host_done_d = host_p1_q;
        if (host_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (starve_hit)      starve_d = 1'b1;
    else if (starve_clr) starve_d = 1'b0;
    else                 starve_d = starve_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      rem_q         <= '0;
      starve_cnt_q  <= '0;
      starve_q      <= 1'b0;
      disp_p1_q     <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_data_q   <= '0;
      host_p1_q     <= 1'b0;
      host_dvalid_q <= 1'b0;
      host_data_q   <= '0;
      host_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      rem_q         <= rem_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_q      <= starve_d;
      disp_p1_q     <= disp_act;
      disp_valid_q  <= disp_p1_q;
      host_p1_q     <= host_issue;
      host_dvalid_q <= host_p1_q;
      host_done_q   <= host_done_d;
      if (disp_p1_q) disp_data_q <= doutb;
      if (host_p1_q) host_data_q <= doutb;
    end
  end

  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign host_data   = host_data_q;
  assign host_dvalid = host_dvalid_q;
  assign host_done   = host_done_q;
  assign host_busy   = (state_q != IDLE);
  assign host_starve = starve_q;

endmodule

// File: tb/tb_vram_rd_sched.sv
// Directed bench for vram_rd_sched: display-only, host bursts, contention/wrap,
// starvation flag, ignored start and mid-burst reset, with a behavioural VRAM.
module tb_vram_rd_sched;
  localparam int AW = 14;
  localparam int DW = 12;
  localparam logic [AW-1:0] IDA = 14'h2AAA;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_act;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          host_start;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_len;
  logic          host_busy;
  logic [DW-1:0] host_data;
  logic          host_dvalid;
  logic          host_done;
  logic          host_starve;
  logic          starve_clr;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb = '0;

  int n_vec = 0;
  int n_bad = 0;

  logic          ed_v0, ed_v1, eh_v0, eh_v1;
  logic [DW-1:0] ed_d0, ed_d1, eh_d0, eh_d1, ed_last, eh_last;
  logic [AW-1:0] eh_a0, eh_a1;
  int            words_left;

  always #5 clk = ~clk;

  vram_rd_sched #(.AW(AW), .DW(DW), .STARVE_LIMIT(8), .SCW(4)) dut (
    .clk(clk), .rst(rst),
    .disp_act(disp_act), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .host_start(host_start), .host_addr(host_addr), .host_len(host_len),
    .host_busy(host_busy), .host_data(host_data), .host_dvalid(host_dvalid),
    .host_done(host_done), .host_starve(host_starve), .starve_clr(starve_clr),
    .addrb(addrb), .doutb(doutb)
  );

  function automatic logic [DW-1:0] vmem(input logic [AW-1:0] a);
    return a[11:0] ^ {10'h000, a[13:12]} ^ 12'h5A5;
  endfunction

  // One-cycle-latency VRAM read port
  always @(posedge clk) doutb <= vmem(addrb);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    ed_v0 = 0; ed_v1 = 0; eh_v0 = 0; eh_v1 = 0;
    ed_d0 = '0; ed_d1 = '0; eh_d0 = '0; eh_d1 = '0;
    eh_a0 = '0; eh_a1 = '0;
    ed_last = '0; eh_last = '0; words_left = 0;
  endtask

  task automatic check_outs();
    chk("disp_valid", {31'd0, disp_valid}, {31'd0, ed_v1});
    if (ed_v1) ed_last = ed_d1;
    chk("disp_data", {20'd0, disp_data}, {20'd0, ed_last});
    chk("host_dvalid", {31'd0, host_dvalid}, {31'd0, eh_v1});
    if (eh_v1) begin
      eh_last = eh_d1;
      $display("host word addr=0x%04h data=0x%03h", eh_a1, host_data);
    end
    chk("host_data", {20'd0, host_data}, {20'd0, eh_last});
    chk("host_done", {31'd0, host_done}, {31'd0, (eh_v1 && words_left == 1)});
    if (eh_v1 && words_left > 0) words_left--;
  endtask

  task automatic cyc(input logic act, input logic [AW-1:0] daddr, input logic start,
                     input logic [AW-1:0] haddr, input logic [7:0] hlen, input logic clr,
                     input logic hiss, input logic [AW-1:0] hexp);
    check_outs();
    disp_act = act; disp_addr = daddr; host_start = start;
    host_addr = haddr; host_len = hlen; starve_clr = clr;
    #1;
    chk("addrb", {18'd0, addrb}, {18'd0, (hiss ? hexp : daddr)});
    ed_v1 = ed_v0; ed_d1 = ed_d0; ed_v0 = act;  ed_d0 = vmem(daddr);
    eh_v1 = eh_v0; eh_d1 = eh_d0; eh_a1 = eh_a0;
    eh_v0 = hiss; eh_d0 = vmem(hexp); eh_a0 = hexp;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b0, 14'h0);
  endtask

  initial begin
    rst = 1'b1; disp_act = 0; disp_addr = IDA; host_start = 0;
    host_addr = '0; host_len = '0; starve_clr = 0;
    clear_exp();
    @(posedge clk); #1;
    @(posedge clk); #1;
    // 1: reset then idle
    chk("rst_busy", {31'd0, host_busy}, 32'd0);
    chk("rst_starve", {31'd0, host_starve}, 32'd0);
    rst = 1'b0;
    idle(3);
    chk("idle_busy", {31'd0, host_busy}, 32'd0);

    // 2: display only
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 14'h0010 + 14'(i), 1'b0, 14'h0, 8'd0, 1'b0, 1'b0, 14'h0);
    idle(3);

    // 3: host burst in blanking
    words_left = 4;
    cyc(1'b0, IDA, 1'b1, 14'h0100, 8'd4, 1'b0, 1'b0, 14'h0);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b1, 14'h0100 + 14'(i));
    chk("b3_busy_run", {31'd0, host_busy}, 32'd1);
    idle(1);
    chk("b3_busy_done", {31'd0, host_busy}, 32'd1);
    idle(1);
    chk("b3_busy_off", {31'd0, host_busy}, 32'd0);
    idle(1);

    // 4: contention with address wrap
    words_left = 4;
    cyc(1'b0, IDA, 1'b1, 14'h3FFE, 8'd4, 1'b0, 1'b0, 14'h0);
    for (int j = 0; j < 12; j++) begin
      if (j % 2 == 0)
        cyc(1'b1, 14'h0020 + 14'(j / 2), 1'b0, 14'h0, 8'd0, 1'b0, 1'b0, 14'h0);
      else
        cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, (j < 8), 14'h3FFE + 14'(j / 2));
    end
    idle(3);
    chk("b4_busy_off", {31'd0, host_busy}, 32'd0);

    // 5: starvation (limit 8)
    words_left = 2;
    cyc(1'b0, IDA, 1'b1, 14'h0400, 8'd2, 1'b0, 1'b0, 14'h0);
    for (int j = 0; j < 20; j++) begin
      chk("starve_rise", {31'd0, host_starve}, {31'd0, (j >= 8)});
      chk("starve_busy", {31'd0, host_busy}, 32'd1);
      cyc(1'b1, 14'h0030 + 14'(j), 1'b0, 14'h0, 8'd0, 1'b0, 1'b0, 14'h0);
    end
    cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b1, 14'h0400);
    cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b1, 14'h0401);
    idle(4);
    chk("starve_sticky", {31'd0, host_starve}, 32'd1);
    chk("starve_idle", {31'd0, host_busy}, 32'd0);
    cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b1, 1'b0, 14'h0);
    chk("starve_clr", {31'd0, host_starve}, 32'd0);

    // 6: start ignored in RUN, then reset mid 256-word burst
    words_left = 256;
    cyc(1'b0, IDA, 1'b1, 14'h0200, 8'd0, 1'b0, 1'b0, 14'h0);
    cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b1, 14'h0200);
    cyc(1'b0, IDA, 1'b1, 14'h0300, 8'd1, 1'b0, 1'b1, 14'h0201);
    cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b1, 14'h0202);
    cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b1, 14'h0203);
    check_outs();
    disp_act = 1'b0; disp_addr = IDA; host_start = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_dvalid", {31'd0, host_dvalid}, 32'd0);
    chk("abort_busy", {31'd0, host_busy}, 32'd0);
    chk("abort_data", {20'd0, host_data}, 32'd0);
    chk("abort_done", {31'd0, host_done}, 32'd0);
    chk("abort_disp_data", {20'd0, disp_data}, 32'd0);
    chk("abort_addrb", {18'd0, addrb}, {18'd0, IDA});
    clear_exp();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    words_left = 1;
    cyc(1'b0, IDA, 1'b1, 14'h0005, 8'd1, 1'b0, 1'b0, 14'h0);
    cyc(1'b0, IDA, 1'b0, 14'h0, 8'd0, 1'b0, 1'b1, 14'h0005);
    idle(4);
    chk("fresh_busy_off", {31'd0, host_busy}, 32'd0);
    chk("fresh_words_left", words_left, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
